// File: rtl/multi_channel_interval_tracker.sv
// multi_channel_interval_tracker: per-cycle history of NUM_CHANNELS tracked/corroborating pairs with
// an on-request serial scan that reports the first activity interval after a channel's previous end.
// Ports:
//    clk, rst                           clock, synchronous active-high reset
//    tracked_signal, corroborating_signal  per-channel levels captured every cycle
//    req_valid/req_ready, req_channel, req_lookback   query handshake (window = newest L entries)
//    resp_valid/resp_ready, resp_start, resp_end, resp_start_found, resp_end_found, resp_err   response
//    end_upd_valid, end_upd_channel, end_upd_value    external previous-end override
//    now                                timestamp of the most recently written entry
module multi_channel_interval_tracker #(
   parameter int NUM_CHANNELS = 4,
   parameter int DEPTH        = 16,
   parameter int TIME_WIDTH   = 32,
   localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CHANNELS-1:0] tracked_signal,
   input  logic [NUM_CHANNELS-1:0] corroborating_signal,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [CW-1:0]           req_channel,
   input  logic [LW-1:0]           req_lookback,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [TIME_WIDTH-1:0]   resp_start,
   output logic [TIME_WIDTH-1:0]   resp_end,
   output logic                    resp_start_found,
   output logic                    resp_end_found,
   output logic                    resp_err,
   input  logic                    end_upd_valid,
   input  logic [CW-1:0]           end_upd_channel,
   input  logic [TIME_WIDTH-1:0]   end_upd_value,
   output logic [TIME_WIDTH-1:0]   now
);
   localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, RESP = 2'd2;
   logic [1:0] state;
   logic [AW-1:0] wptr, rd_ptr, rd_idx;
   logic [LW-1:0] fill, snap_l, cnt;
   logic [CW-1:0] snap_ch, rd_ch;
   logic [TIME_WIDTH-1:0] scan_time, res_start, res_end, nxt_end, diff;
   logic res_sf, res_ef, res_err, rd_trk, rd_cor;
   logic accept, bad, hit, fall, nxt_ef, done;
   logic [NUM_CHANNELS-1:0] trk_mem [DEPTH];
   logic [NUM_CHANNELS-1:0] cor_mem [DEPTH];
   logic [TIME_WIDTH-1:0] prev_end [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] prev_ok;
   assign req_ready        = state == IDLE;
   assign resp_valid       = state == RESP;
   assign resp_start       = resp_valid ? res_start : '0;
   assign resp_end         = resp_valid ? res_end : '0;
   assign resp_start_found = resp_valid && res_sf;
   assign resp_end_found   = resp_valid && res_ef;
   assign resp_err         = resp_valid && res_err;
   assign accept = req_valid && req_ready;
   assign bad    = req_lookback == '0 || req_lookback > fill || 32'(req_channel) >= NUM_CHANNELS;
   // The history is read through a register: the oldest entry of a full window is read on the
   // same edge that overwrites it, so the scan still sees pre-accept data, one entry ahead each cycle.
   assign rd_idx = state == IDLE ? wptr - AW'(req_lookback) + AW'(1) : rd_ptr;
   assign rd_ch  = state == IDLE ? req_channel : snap_ch;
   assign diff   = scan_time - prev_end[snap_ch];
   assign hit    = !res_sf && rd_trk && (!prev_ok[snap_ch] || $signed(diff) > 0);
   assign fall   = res_sf && !rd_trk;
   // A corroborated entry inside a started interval is a candidate end; a falling tracked edge overrides it.
   assign nxt_end = fall ? scan_time - 1'b1 : (hit || res_sf) && rd_cor ? scan_time : res_end;
   assign nxt_ef  = res_ef || fall || ((hit || res_sf) && rd_cor);
   assign done    = (hit && rd_cor) || fall || cnt == snap_l - 1'b1;
   always_ff @(posedge clk)
      if (!rst) begin
         trk_mem[wptr + AW'(1)] <= tracked_signal;
         cor_mem[wptr + AW'(1)] <= corroborating_signal;
      end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wptr    <= '1;
         now     <= '0;
         fill    <= '0;
         prev_ok <= '0;
      end else begin
         wptr   <= wptr + AW'(1);
         now    <= now + 1'b1;
         fill   <= fill == LW'(DEPTH) ? fill : fill + 1'b1;
         rd_trk <= trk_mem[rd_idx][rd_ch];
         rd_cor <= cor_mem[rd_idx][rd_ch];
         rd_ptr <= rd_idx + AW'(1);
         case (state)
            IDLE:
               if (accept) begin
                  snap_ch   <= req_channel;
                  snap_l    <= req_lookback;
                  cnt       <= '0;
                  scan_time <= now - TIME_WIDTH'(req_lookback) + 1'b1;
                  res_start <= '0;
                  res_end   <= '0;
                  res_sf    <= 1'b0;
                  res_ef    <= 1'b0;
                  res_err   <= bad;
                  state     <= bad ? RESP : SCAN;
               end
            SCAN: begin
               cnt       <= cnt + 1'b1;
               scan_time <= scan_time + 1'b1;
               res_sf    <= res_sf || hit;
               res_start <= hit ? scan_time : res_start;
               res_end   <= nxt_end;
               res_ef    <= nxt_ef;
               if (done) begin
                  state <= RESP;
                  if (nxt_ef) begin
                     prev_end[snap_ch] <= nxt_end;
                     prev_ok[snap_ch]  <= 1'b1;
                  end
               end
            end
            RESP: state <= resp_ready ? IDLE : RESP;
            default: state <= IDLE;
         endcase
         // Placed last so an external override beats a same-cycle internal update.
         if (end_upd_valid) begin
            prev_end[end_upd_channel] <= end_upd_value;
            prev_ok[end_upd_channel]  <= 1'b1;
         end
      end
   end
endmodule
